// File: rtl/motor_ramp_scheduler.sv
// motor_ramp_scheduler
// Keeps a target and a current PWM period for every motor channel. On each
// ramp tick it visits the channels in order and moves each current period
// one bounded step toward its target. Every change leaves through a single
// registered write port. Immediate commands take that port first and stall
// the scan for the cycle they use.
//
// Handshake: i_cmd_valid is a one-cycle strobe with no back-pressure. Every
// strobe is answered exactly one cycle later by either o_cmd_ack (command
// applied) or o_cmd_err (address out of range, command dropped). o_wr_en is
// a one-cycle strobe; o_wr_addr and o_wr_period are valid only while it is high.
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_cmd_valid     command strobe
//   i_cmd_addr      motor index of the command
//   i_cmd_period    new target period
//   i_cmd_immediate 1 = also set current = target now, with no ramp
//   i_step_size     largest change per tick per channel (0 acts as 1)
//   o_cmd_ack       pulse: command accepted
//   o_cmd_err       pulse: address out of range, command dropped
//   o_wr_en         write strobe to the period register file
//   o_wr_addr       channel being written
//   o_wr_period     value being written
//   o_at_target     bit i = channel i current equals target (registered)
//   o_scan_busy     FSM state: high while scanning
module motor_ramp_scheduler #(
  parameter int NUM_MOTORS = 24,
  parameter int PERIOD_W   = 11,
  parameter int RAMP_DIV   = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  input  logic [7:0]            i_cmd_addr,
  input  logic [PERIOD_W-1:0]   i_cmd_period,
  input  logic                  i_cmd_immediate,
  input  logic [PERIOD_W-1:0]   i_step_size,
  output logic                  o_cmd_ack,
  output logic                  o_cmd_err,
  output logic                  o_wr_en,
  output logic [7:0]            o_wr_addr,
  output logic [PERIOD_W-1:0]   o_wr_period,
  output logic [NUM_MOTORS-1:0] o_at_target,
  output logic                  o_scan_busy
);

  localparam int                  PRESC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int                  IDX_W      = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
  localparam logic [8:0]          NUM_M9     = 9'(NUM_MOTORS);
  localparam logic [7:0]          LAST_IDX   = 8'(NUM_MOTORS - 1);
  localparam logic [PERIOD_W-1:0] ONE        = PERIOD_W'(1);

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [PRESC_W-1:0]    r_presc;
  logic [7:0]            r_index;
  logic                  r_pending;
  logic [PERIOD_W-1:0]   r_target  [NUM_MOTORS];
  logic [PERIOD_W-1:0]   r_current [NUM_MOTORS];
  logic                  r_cmd_ack;
  logic                  r_cmd_err;
  logic                  r_wr_en;
  logic [7:0]            r_wr_addr;
  logic [PERIOD_W-1:0]   r_wr_period;
  logic [NUM_MOTORS-1:0] r_at_target;

  logic                  w_tick;
  logic                  w_addr_ok;
  logic                  w_cmd_ok;
  logic                  w_cmd_imm;
  logic                  w_visit;
  logic                  w_last;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_cmd_idx;
  logic [PERIOD_W-1:0]   w_cur;
  logic [PERIOD_W-1:0]   w_tgt;
  logic [PERIOD_W-1:0]   w_step_eff;
  logic [PERIOD_W-1:0]   w_diff;
  logic [PERIOD_W-1:0]   w_delta;
  logic [PERIOD_W-1:0]   w_new;
  logic                  w_up;
  logic                  w_need;

  // Command decode
  assign w_addr_ok = ({1'b0, i_cmd_addr} < NUM_M9);
  assign w_cmd_ok  = i_cmd_valid & w_addr_ok;
  assign w_cmd_imm = w_cmd_ok & i_cmd_immediate;
  assign w_cmd_idx = i_cmd_addr[IDX_W-1:0];
  assign w_tick    = (r_presc == PRESC_LAST);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM: next state. A tick that lands on the last visit restarts the scan
  // directly, so it does not need to go through the pending flag.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_tick || r_pending) w_next_state = S_SCAN;
      S_SCAN: if (w_last && !(r_pending || w_tick)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs. An immediate command owns the write port, so the scan
  // visit is suppressed and the same index is visited again next cycle.
  always_comb begin
    o_scan_busy = (r_state == S_SCAN);
    w_visit     = (r_state == S_SCAN) && !w_cmd_imm;
    w_last      = w_visit && (r_index == LAST_IDX);
  end

  // Slew of the visited channel. The arithmetic is unsigned, and the step
  // is clamped to the distance so the result never passes the target.
  assign w_idx      = r_index[IDX_W-1:0];
  assign w_cur      = r_current[w_idx];
  assign w_tgt      = r_target[w_idx];
  assign w_need     = (w_cur != w_tgt);
  assign w_up       = (w_tgt > w_cur);
  assign w_step_eff = (i_step_size == '0) ? ONE : i_step_size;
  assign w_diff     = w_up ? (w_tgt - w_cur) : (w_cur - w_tgt);
  assign w_delta    = (w_step_eff < w_diff) ? w_step_eff : w_diff;
  assign w_new      = w_up ? (w_cur + w_delta) : (w_cur - w_delta);

  // Prescaler, scan index and pending tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc   <= '0;
      r_index   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_visit) r_index <= (r_index == LAST_IDX) ? 8'd0 : r_index + 8'd1;
      if (w_last) r_pending <= 1'b0;
      else if (w_tick && r_state == S_SCAN) r_pending <= 1'b1;
    end
  end

  // Channel state and the registered write port. The scan reads the target
  // before this edge, so a same-cycle command to the visited channel only
  // counts from the next visit of that channel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        r_target[i]  <= ONE;
        r_current[i] <= ONE;
      end
      r_cmd_ack   <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_period <= '0;
      r_at_target <= '1;
    end else begin
      r_cmd_ack <= w_cmd_ok;
      r_cmd_err <= i_cmd_valid && !w_addr_ok;
      if (w_cmd_ok) r_target[w_cmd_idx] <= i_cmd_period;
      if (w_cmd_imm) begin
        r_current[w_cmd_idx] <= i_cmd_period;
      end else if (w_visit && w_need) begin
        r_current[w_idx] <= w_new;
      end
      r_wr_en <= w_cmd_imm || (w_visit && w_need);
      if (w_cmd_imm) begin
        r_wr_addr   <= i_cmd_addr;
        r_wr_period <= i_cmd_period;
      end else if (w_visit && w_need) begin
        r_wr_addr   <= r_index;
        r_wr_period <= w_new;
      end
      for (int i = 0; i < NUM_MOTORS; i++) begin
        r_at_target[i] <= (r_current[i] == r_target[i]);
      end
    end
  end

  assign o_cmd_ack   = r_cmd_ack;
  assign o_cmd_err   = r_cmd_err;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_period = r_wr_period;
  assign o_at_target = r_at_target;

endmodule

// File: doc/motor_ramp_scheduler.md
Name: motor_ramp_scheduler

Overview:
- Sits between the SPI command decoder and the PWM period register file.
- Holds a target and a current period per motor channel.
- On each ramp tick it walks all channels round-robin and slews each current period toward its target by a bounded step. Every change is issued on a single write port that feeds the PWM generators.
- Immediate commands bypass the ramp and take priority on the write port.

Parameters:
- NUM_MOTORS, 24, number of channels (max 256).
- PERIOD_W, 11, period/step width in bits.
- RAMP_DIV, 50000, clk cycles per ramp tick (1 ms at 50 MHz); must be >= NUM_MOTORS+4.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  one-cycle command strobe
- cmd_addr  in  8  motor index
- cmd_period  in  PERIOD_W  new target period
- cmd_immediate  in  1  1 = set current=target at once, no ramp
- step_size  in  PERIOD_W  max change per tick per channel; 0 treated as 1
- cmd_ack  out  1  pulse: command accepted
- cmd_err  out  1  pulse: cmd_addr >= NUM_MOTORS, command dropped
- wr_en  out  1  write strobe to period register file
- wr_addr  out  8  channel written
- wr_period  out  PERIOD_W  value written
- at_target  out  NUM_MOTORS  bit i = (current[i] == target[i])
- scan_busy  out  1  high while FSM is in SCAN

Behaviour:
- Reset (reset=0, async):
  - target[i]=current[i]=1 for all i; prescaler=0; FSM=IDLE; index=0; pending=0.
  - Outputs: cmd_ack=cmd_err=wr_en=0, wr_addr=0, wr_period=0, at_target=all 1s, scan_busy=0.
  - Reset asserted mid-scan aborts the scan. No write is issued after release until the next tick.
- Prescaler:
  - Counts 0..RAMP_DIV-1 and wraps.
  - The wrap cycle raises tick for one cycle.
  - A tick in IDLE moves the FSM to SCAN. A tick during SCAN sets pending; pending is consumed at SCAN end.
- FSM:
  - IDLE: waits for tick or pending.
  - SCAN: one channel per cycle, index 0..NUM_MOTORS-1.
    - For channel i: if current != target, diff=|target-current| and d=min(max(step_size,1),diff). current moves by d toward target. Arithmetic is unsigned; clamping to target prevents overflow or underflow.
    - A write of the new value (wr_en=1, wr_addr=i, wr_period=new) is registered and appears 1 cycle after the visit.
    - If current == target, no write is issued.
    - After index NUM_MOTORS-1, the FSM returns to IDLE, or re-enters SCAN at index 0 if pending is set.
- Commands (any state, one per cycle):
  - cmd_addr >= NUM_MOTORS: cmd_err=1 the next cycle; no state change, no write.
  - Otherwise: target[addr]=cmd_period and cmd_ack=1 the next cycle.
  - With cmd_immediate: current[addr]=cmd_period too, and wr_en/addr/period are issued the next cycle.
- Arbitration (single write port):
  - An immediate command has priority.
  - In that cycle SCAN stalls: index holds, no scan write, and the channel is re-evaluated the following cycle using the updated state.
- Same-cycle hazards:
  - Non-immediate command to the channel being scanned: the scan uses the old target. The new target takes effect on the next tick.
  - Command while IDLE at a tick edge: the command is applied first; the scan starts the same cycle FSM enters SCAN, visiting index 0 next cycle.
- at_target: registered; updates 1 cycle after any change to current or target.
- wr_en is never high for 2 writes to the same channel within one scan, except after an immediate-command stall.

Test Plan:
- Use RAMP_DIV=40 and NUM_MOTORS=24 for simulation.
- Reset, then idle 200 cycles -> no wr_en; at_target=24'hFFFFFF; cmd_ack=cmd_err=0.
- cmd addr=3, period=1001, immediate=0, step=250 -> cmd_ack next cycle; across successive ticks, wr to addr 3 with 251, 501, 751, 1001, then none; at_target[3]=1 after the 1001 write.
- cmd addr=5, period=700, immediate=1, issued while the scan is writing channel 2 (step=100, target[2]=900, current[2]=1) -> next cycle wr_addr=5, wr_period=700; the scan stalls one cycle, then resumes and writes channel 2 with 101.
- cmd addr=24, then addr=200 -> cmd_err pulses each time; no wr_en; targets unchanged.
- step_size=0, target[0]=4 -> writes 2, 3, 4 on three consecutive ticks.
- Target ramp down: current[7]=1001, target 1, step=400 -> writes 601, 201, 1.
- Assert reset 5 cycles into a scan, release -> outputs at reset values, no wr_en until the next tick; the next tick's scan starts at index 0.
